// File: rtl/product_accumulator_pkg.sv
// Shared constants for the product accumulator: FSM encoding, width defaults
// matched to the upstream multiplier, and a constant clog2.
package product_accumulator_pkg;

  localparam int DEF_BITWIDTH_A = 8;
  localparam int DEF_BITWIDTH_B = 8;
  localparam int DEF_PROD_WIDTH = DEF_BITWIDTH_A + DEF_BITWIDTH_B;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_MAX_TERMS  = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/product_accumulator.sv
// Streaming group accumulator: sums unsigned products until in_last or MAX_TERMS,
// then holds the result on a valid/ready port. in_ready doubles as multiplier enable.
//
// state    | meaning
// ST_ACCUM | accepting products into the open group
// ST_HOLD  | result presented, waiting for out_ready
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int MAX_TERMS  = DEF_MAX_TERMS,
  parameter int CNT_W      = clog2(MAX_TERMS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_product,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_W-1:0]      out_terms,
  output logic                  out_overflow,
  output logic                  busy
);

  acc_state_e           state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]     count_q;
  logic                 ovf_q;
  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] out_sum_q;
  logic [CNT_W-1:0]     out_terms_q;
  logic                 out_overflow_q;

  logic [ACC_WIDTH:0]   sum_d;
  logic [CNT_W-1:0]     count_d;
  logic                 accept;
  logic                 close;

  // Depends only on state and reset, never on in_valid or out_ready.
  assign in_ready = (state_q == ST_ACCUM) && !rst;
  assign accept   = in_valid && in_ready;
  assign sum_d    = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, in_product};
  assign count_d  = count_q + 1'b1;
  assign close    = in_last || (count_d == CNT_W'(MAX_TERMS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_ACCUM;
      acc_q          <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_terms_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            if (close) begin
              out_sum_q      <= sum_d[ACC_WIDTH-1:0];
              out_terms_q    <= count_d;
              out_overflow_q <= ovf_q | sum_d[ACC_WIDTH];
              out_valid_q    <= 1'b1;
              acc_q          <= '0;
              count_q        <= '0;
              ovf_q          <= 1'b0;
              state_q        <= ST_HOLD;
            end else begin
              acc_q   <= sum_d[ACC_WIDTH-1:0];
              count_q <= count_d;
              ovf_q   <= ovf_q | sum_d[ACC_WIDTH];
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACCUM;
          end
        end
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_terms    = out_terms_q;
  assign out_overflow = out_overflow_q;
  assign busy         = (count_q != '0) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: four accumulator configurations share one stimulus stream;
// a group-level model predicts each result, a monitor checks what each DUT emits.
module tb_product_accumulator;

  localparam int N = 4;

  typedef struct {
    int     inst;
    longint sum;
    int     terms;
    bit     ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [15:0] in_product;

  logic [N-1:0] ir, ov, by, of;
  logic [31:0]  sm [N];
  logic [7:0]   tm [N];

  logic [23:0] s0; logic [4:0] t0;
  logic [17:0] s1; logic [3:0] t1;
  logic [23:0] s2; logic [2:0] t2;
  logic [23:0] s3; logic [0:0] t3;

  assign sm[0] = 32'(s0); assign tm[0] = 8'(t0);
  assign sm[1] = 32'(s1); assign tm[1] = 8'(t1);
  assign sm[2] = 32'(s2); assign tm[2] = 8'(t2);
  assign sm[3] = 32'(s3); assign tm[3] = 8'(t3);

  int acc_w [N] = '{24, 18, 24, 24};
  int max_t [N] = '{16, 8, 4, 1};

  bit     m_hold  [N];
  int     m_terms [N];
  longint m_total [N];
  exp_t   sb [$];

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(24), .MAX_TERMS(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_product(in_product),
    .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_sum(s0),
    .out_terms(t0), .out_overflow(of[0]), .busy(by[0]));
  product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(18), .MAX_TERMS(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_product(in_product),
    .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_sum(s1),
    .out_terms(t1), .out_overflow(of[1]), .busy(by[1]));
  product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(24), .MAX_TERMS(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_product(in_product),
    .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .out_sum(s2),
    .out_terms(t2), .out_overflow(of[2]), .busy(by[2]));
  product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(24), .MAX_TERMS(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_product(in_product),
    .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready), .out_sum(s3),
    .out_terms(t3), .out_overflow(of[3]), .busy(by[3]));

  task automatic check(input string nm, input longint act, input longint exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Group-level reference: a group is a running true sum and a term count.
  initial begin
    exp_t   e;
    longint modv;
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          m_hold[i]  = 1'b0;
          m_terms[i] = 0;
          m_total[i] = 0;
          for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].inst == i) sb.delete(k);
        end else if (m_hold[i]) begin
          if (out_ready) m_hold[i] = 1'b0;
        end else if (in_valid) begin
          m_terms[i] = m_terms[i] + 1;
          m_total[i] = m_total[i] + longint'(in_product);
          if (in_last || m_terms[i] == max_t[i]) begin
            modv    = longint'(1) << acc_w[i];
            e.inst  = i;
            e.sum   = m_total[i] % modv;
            e.terms = m_terms[i];
            e.ovf   = (m_total[i] >= modv);
            sb.push_back(e);
            m_hold[i]  = 1'b1;
            m_terms[i] = 0;
            m_total[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    int idx;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        check($sformatf("in_ready[%0d]", i), longint'(ir[i]), longint'(!m_hold[i] && !rst));
        check($sformatf("out_valid[%0d]", i), longint'(ov[i]), longint'(m_hold[i]));
        check($sformatf("busy[%0d]", i), longint'(by[i]), longint'(m_hold[i] || m_terms[i] != 0));
        if (ov[i]) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++)
            if (idx < 0 && sb[k].inst == i) idx = k;
          if (idx < 0) begin
            ntotal++;
            $display("FAIL sb_empty[%0d]: got out_valid=1 expected no result at %0t", i, $time);
          end else begin
            check($sformatf("out_sum[%0d]", i), longint'(sm[i]), sb[idx].sum);
            check($sformatf("out_terms[%0d]", i), longint'(tm[i]), longint'(sb[idx].terms));
            check($sformatf("out_overflow[%0d]", i), longint'(of[i]), longint'(sb[idx].ovf));
            if (out_ready && !rst) sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [15:0] p, input bit l, input bit r, input bit rs);
    in_valid   = v;
    in_product = p;
    in_last    = l;
    out_ready  = r;
    rst        = rs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [15:0] p;
    rst = 1'b1; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_sum[%0d]", i), longint'(sm[i]), 0);
      check($sformatf("reset_terms[%0d]", i), longint'(tm[i]), 0);
      check($sformatf("reset_ovf[%0d]", i), longint'(of[i]), 0);
    end
    @(negedge clk);

    cyc(1, 16'd3, 0, 1, 0); cyc(1, 16'd5, 0, 1, 0); cyc(1, 16'd7, 1, 1, 0); idle(3);
    for (int k = 1; k <= 6; k++) cyc(1, 16'(k), 0, 1, 0);
    idle(2); cyc(1, 16'd0, 1, 1, 0); idle(3);
    for (int k = 1; k <= 5; k++) cyc(1, 16'hFFFF, k == 5, 1, 0);
    idle(2); cyc(1, 16'd1, 1, 1, 0); idle(3);
    cyc(1, 16'd2, 0, 0, 0); cyc(1, 16'd2, 1, 0, 0);
    repeat (5) cyc(0, 16'd0, 0, 0, 0);
    cyc(0, 16'd0, 0, 1, 0); idle(2);
    cyc(1, 16'd9, 0, 1, 0); cyc(1, 16'd9, 0, 1, 0); cyc(0, 16'd0, 0, 1, 1);
    cyc(1, 16'd4, 1, 1, 0); idle(3);
    cyc(1, 16'd10, 0, 1, 0); cyc(0, 16'd0, 0, 1, 0); cyc(1, 16'd20, 1, 1, 0); cyc(0, 16'd0, 0, 1, 0);
    idle(3);

    for (int n = 0; n < 800; n++) begin
      p = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      cyc($urandom_range(0, 3) != 0, p, $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
    end
    idle(20);

    check("sb_drained", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
